control_unit: RTL and testbench

- Hardwired Moore sequencer driving every control input of the Mini SRC datapath.
- Walks the fetch / decode / execute T-states for each opcode.
- Consumes the IR contents and the branch condition flip-flop output from the datapath.
- Sits beside the datapath in the top-level CPU; the datapath contains no sequencing of its own.

---
 rtl/mini_src_pkg.sv | 42 ++++
 rtl/opcode_class_decode.sv | 33 +++
 rtl/control_unit.sv | 174 +++++++++++++++++
 tb/tb_control_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC control path: opcodes, sequencer states,
// instruction classes and the bundle of datapath control strobes.
package mini_src_pkg;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SHL  = 5'b01011;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_DIV  = 5'b01111;
    localparam logic [4:0] OPC_MUL  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_BR   = 5'b10011;
    localparam logic [4:0] OPC_JR   = 5'b10100;
    localparam logic [4:0] OPC_JAL  = 5'b10101;
    localparam logic [4:0] OPC_IN   = 5'b10110;
    localparam logic [4:0] OPC_OUT  = 5'b10111;
    localparam logic [4:0] OPC_MFHI = 5'b11000;
    localparam logic [4:0] OPC_MFLO = 5'b11001;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, HALT
    } state_t;

    typedef struct packed {
        logic rtype, imm, ldi, ld, st, muldiv, unary, br, single, halt, nop;
    } op_class_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout;
        logic yin, hiin, hiout, loin, loout, zin, zhighout, zlowout;
        logic pcin, pcout, incpc, irin;
        logic marin, mdrin, mdrout, read, mem_read, mem_write;
        logic cout, inportout, outportin, conin;
    } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps the 5-bit opcode onto a one-hot instruction class so the sequencer
// only has to branch on a handful of execution shapes.
module opcode_class_decode
    import mini_src_pkg::*;
#(
    parameter logic [4:0] HALT_OPC = OPC_HALT
) (
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        if (opcode == HALT_OPC) begin
            op_class.halt = 1'b1;
        end else begin
            case (opcode) inside
                OPC_LD:                                     op_class.ld     = 1'b1;
                OPC_LDI:                                    op_class.ldi    = 1'b1;
                OPC_ST:                                     op_class.st     = 1'b1;
                [OPC_ADD:OPC_SHL]:                          op_class.rtype  = 1'b1;
                [OPC_ADDI:OPC_ORI]:                         op_class.imm    = 1'b1;
                OPC_MUL, OPC_DIV:                           op_class.muldiv = 1'b1;
                OPC_NEG, OPC_NOT:                           op_class.unary  = 1'b1;
                OPC_BR:                                     op_class.br     = 1'b1;
                OPC_JR, OPC_IN, OPC_OUT, OPC_MFHI, OPC_MFLO: op_class.single = 1'b1;
                // jal is reserved and behaves like nop, as do undefined opcodes
                default:                                    op_class.nop    = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch T0-T3, then an
// opcode-dependent execute sequence, with outputs decoded from (state, ir).
module control_unit
    import mini_src_pkg::*;
#(
    parameter logic [4:0] HALT_OPC = 5'b11011,
    parameter logic [4:0] ADD_OPC  = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        Yin, Hiin, Hiout, LOin, LOout, Zin, Zhighout, Zlowout,
    output logic        PCin, PCout, IncPC, IRin,
    output logic        MARin, MDRin, MDRout, Read,
    output logic        memRead, memWrite,
    output logic        Cout, InPortOut, OutPortIn, CONin,
    output logic [4:0]  alu_op,
    output logic        run
);

    state_t    state, next_state;
    op_class_t cls;
    ctrl_t     c, c_out;
    logic [4:0] opcode, alu;

    // Operand fields belong to the datapath; only the opcode steers sequencing.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[26:0];

    assign opcode = ir[31:27];

    opcode_class_decode #(.HALT_OPC(HALT_OPC)) u_decode (
        .opcode   (opcode),
        .op_class (cls)
    );

    // NOTE: clear is synchronous, so it appears only inside the clocked branch.
    always_ff @(posedge clock) begin
        if (clear) state <= T0;
        else       state <= next_state;
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = T0;
        c          = '0;
        alu        = opcode;
        unique case (state)
            T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1; next_state = T1; end
            T1: begin c.zlowout = 1'b1; c.pcin = 1'b1; c.mem_read = 1'b1; next_state = T2; end
            T2: begin c.mem_read = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; next_state = T3; end
            T3: begin c.mdrout = 1'b1; c.irin = 1'b1; next_state = T4; end
            T4: begin
                next_state = T5;
                if (cls.rtype || cls.imm) begin
                    c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1;
                end else if (cls.ldi || cls.ld || cls.st) begin
                    c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1;
                end else if (cls.muldiv) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1;
                end else if (cls.unary) begin
                    c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1;
                end else if (cls.br) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1;
                end else if (cls.halt) begin
                    next_state = HALT;
                end else begin
                    next_state = T0;
                    case (opcode)
                        OPC_JR:   begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
                        OPC_IN:   begin c.inportout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                        OPC_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.outportin = 1'b1; end
                        OPC_MFHI: begin c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                        OPC_MFLO: begin c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                        default:  ;
                    endcase
                end
            end
            T5: begin
                next_state = T6;
                if (cls.rtype) begin
                    c.grc = 1'b1; c.rout = 1'b1; c.zin = 1'b1;
                end else if (cls.imm) begin
                    c.cout = 1'b1; c.zin = 1'b1;
                end else if (cls.ldi || cls.ld || cls.st) begin
                    c.cout = 1'b1; c.zin = 1'b1; alu = ADD_OPC;
                end else if (cls.muldiv) begin
                    c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1;
                end else if (cls.unary) begin
                    c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; next_state = T0;
                end else if (cls.br) begin
                    c.pcout = 1'b1; c.yin = 1'b1;
                end else begin
                    next_state = T0;
                end
            end
            T6: begin
                next_state = T7;
                if (cls.ld || cls.st) begin
                    c.zlowout = 1'b1; c.marin = 1'b1;
                end else if (cls.muldiv) begin
                    c.zlowout = 1'b1; c.loin = 1'b1;
                end else if (cls.br) begin
                    c.cout = 1'b1; c.zin = 1'b1; alu = ADD_OPC;
                end else if (cls.rtype || cls.imm || cls.ldi) begin
                    c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; next_state = T0;
                end else begin
                    next_state = T0;
                end
            end
            T7: begin
                next_state = T0;
                if (cls.ld) begin
                    c.mem_read = 1'b1; next_state = T8;
                end else if (cls.st) begin
                    c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1; next_state = T8;
                end else if (cls.muldiv) begin
                    c.zhighout = 1'b1; c.hiin = 1'b1;
                end else if (cls.br) begin
                    c.zlowout = 1'b1; c.pcin = con_ff;
                end
            end
            T8: begin
                next_state = T0;
                if (cls.ld) begin
                    c.mem_read = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; next_state = T9;
                end else if (cls.st) begin
                    c.mem_write = 1'b1;
                end
            end
            T9: begin
                if (cls.ld) begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            end
            HALT: begin next_state = HALT; alu = '0; end
            default: ;
        endcase
    end

    assign c_out  = clear ? '0 : c;
    assign alu_op = clear ? 5'd0 : alu;
    assign run    = clear | (state != HALT);

    assign Gra       = c_out.gra;
    assign Grb       = c_out.grb;
    assign Grc       = c_out.grc;
    assign Rin       = c_out.rin;
    assign Rout      = c_out.rout;
    assign BAout     = c_out.baout;
    assign Yin       = c_out.yin;
    assign Hiin      = c_out.hiin;
    assign Hiout     = c_out.hiout;
    assign LOin      = c_out.loin;
    assign LOout     = c_out.loout;
    assign Zin       = c_out.zin;
    assign Zhighout  = c_out.zhighout;
    assign Zlowout   = c_out.zlowout;
    assign PCin      = c_out.pcin;
    assign PCout     = c_out.pcout;
    assign IncPC     = c_out.incpc;
    assign IRin      = c_out.irin;
    assign MARin     = c_out.marin;
    assign MDRin     = c_out.mdrin;
    assign MDRout    = c_out.mdrout;
    assign Read      = c_out.read;
    assign memRead   = c_out.mem_read;
    assign memWrite  = c_out.mem_write;
    assign Cout      = c_out.cout;
    assign InPortOut = c_out.inportout;
    assign OutPortIn = c_out.outportin;
    assign CONin     = c_out.conin;

endmodule

// File: tb/tb_control_unit.sv
// Directed cycle-by-cycle vectors for the Mini SRC sequencer, with hand-built
// sequences for halt parking and clear aborting a load mid-flight.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        con_ff;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Yin, Hiin, Hiout, LOin, LOout, Zin, Zhighout, Zlowout;
    logic PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read;
    logic memRead, memWrite, Cout, InPortOut, OutPortIn, CONin;
    logic [4:0] alu_op;
    logic run;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Yin(Yin), .Hiin(Hiin), .Hiout(Hiout), .LOin(LOin), .LOout(LOout),
        .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
        .memRead(memRead), .memWrite(memWrite),
        .Cout(Cout), .InPortOut(InPortOut), .OutPortIn(OutPortIn), .CONin(CONin),
        .alu_op(alu_op), .run(run)
    );

    always #5 clock = ~clock;

    localparam logic [27:0] GRA = 28'h1 << 27, GRB = 28'h1 << 26, GRC = 28'h1 << 25;
    localparam logic [27:0] RIN = 28'h1 << 24, ROUT = 28'h1 << 23, BAOUT = 28'h1 << 22;
    localparam logic [27:0] YIN = 28'h1 << 21, HIIN = 28'h1 << 20, HIOUT = 28'h1 << 19;
    localparam logic [27:0] LOIN = 28'h1 << 18, LOOUT = 28'h1 << 17, ZIN = 28'h1 << 16;
    localparam logic [27:0] ZHIGHOUT = 28'h1 << 15, ZLOWOUT = 28'h1 << 14;
    localparam logic [27:0] PCIN = 28'h1 << 13, PCOUT = 28'h1 << 12, INCPC = 28'h1 << 11;
    localparam logic [27:0] IRIN = 28'h1 << 10, MARIN = 28'h1 << 9, MDRIN = 28'h1 << 8;
    localparam logic [27:0] MDROUT = 28'h1 << 7, READ = 28'h1 << 6, MEMREAD = 28'h1 << 5;
    localparam logic [27:0] MEMWRITE = 28'h1 << 4, COUT = 28'h1 << 3, INPORTOUT = 28'h1 << 2;
    localparam logic [27:0] OUTPORTIN = 28'h1 << 1, CONIN = 28'h1 << 0;
    localparam logic [27:0] NONE = 28'h0;
    localparam logic [4:0]  ADD = 5'b00011;

    typedef struct {
        logic [95:0] name;
        logic        clear;
        logic [31:0] ir;
        logic        con_ff;
        logic [27:0] ctrl;
        logic [4:0]  alu;
        logic        run;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [27:0] actual_ctrl();
        return {Gra, Grb, Grc, Rin, Rout, BAout, Yin, Hiin, Hiout, LOin, LOout, Zin,
                Zhighout, Zlowout, PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, Read,
                memRead, memWrite, Cout, InPortOut, OutPortIn, CONin};
    endfunction

    task automatic check(input vec_t v);
        logic [27:0] act;
        act = actual_ctrl();
        n_vec++;
        if (act !== v.ctrl || alu_op !== v.alu || run !== v.run) begin
            n_bad++;
            $display("FAIL %0s: ctrl=%07h alu_op=%05b run=%0b, required ctrl=%07h alu_op=%05b run=%0b",
                     v.name, act, alu_op, run, v.ctrl, v.alu, v.run);
        end
    endtask

    // Drive one cycle's inputs, compare mid-cycle, then advance past the next edge.
    task automatic apply(input vec_t v);
        clear  = v.clear;
        ir     = v.ir;
        con_ff = v.con_ff;
        #1;
        check(v);
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [95:0] name, input logic clr, input logic [31:0] i,
                        input logic cf, input logic [27:0] ctrl, input logic [4:0] alu,
                        input logic r);
        vec_t v;
        v.name = name; v.clear = clr; v.ir = i; v.con_ff = cf;
        v.ctrl = ctrl; v.alu = alu; v.run = r;
        vecs.push_back(v);
    endtask

    task automatic push_fetch(input logic [31:0] i);
        logic [4:0] op;
        op = i[31:27];
        push("fetch_T0", 1'b0, i, 1'b0, PCOUT | MARIN | INCPC | ZIN, op, 1'b1);
        push("fetch_T1", 1'b0, i, 1'b0, ZLOWOUT | PCIN | MEMREAD,    op, 1'b1);
        push("fetch_T2", 1'b0, i, 1'b0, MEMREAD | READ | MDRIN,      op, 1'b1);
        push("fetch_T3", 1'b0, i, 1'b0, MDROUT | IRIN,               op, 1'b1);
    endtask

    task automatic push_ld_front(input logic [31:0] i, input logic [95:0] tag);
        push(tag, 1'b0, i, 1'b0, GRB | BAOUT | YIN, i[31:27], 1'b1);
        push(tag, 1'b0, i, 1'b0, COUT | ZIN,        ADD,      1'b1);
        push(tag, 1'b0, i, 1'b0, ZLOWOUT | MARIN,   i[31:27], 1'b1);
    endtask

    localparam logic [31:0] IR_ADD  = 32'h1912_0000;
    localparam logic [31:0] IR_LD   = 32'h0080_0055;
    localparam logic [31:0] IR_ST   = 32'h1000_0010;
    localparam logic [31:0] IR_BR   = 32'h9800_0000;
    localparam logic [31:0] IR_MUL  = 32'h8000_0000;
    localparam logic [31:0] IR_NEG  = 32'h8800_0000;
    localparam logic [31:0] IR_MFHI = 32'hC000_0000;
    localparam logic [31:0] IR_ADDI = 32'h6000_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    initial begin
        vec_t v;
        clear = 1'b1; ir = '0; con_ff = 1'b0;

        push("clear_0", 1'b1, 32'h0, 1'b0, NONE, 5'd0, 1'b1);
        push("clear_1", 1'b1, 32'h0, 1'b0, NONE, 5'd0, 1'b1);

        push_fetch(IR_ADD);
        push("add_T4", 1'b0, IR_ADD, 1'b0, GRB | ROUT | YIN,     5'b00011, 1'b1);
        push("add_T5", 1'b0, IR_ADD, 1'b0, GRC | ROUT | ZIN,     5'b00011, 1'b1);
        push("add_T6", 1'b0, IR_ADD, 1'b0, ZLOWOUT | GRA | RIN,  5'b00011, 1'b1);

        push_fetch(IR_LD);
        push_ld_front(IR_LD, "ld_T4_T6");
        push("ld_T7", 1'b0, IR_LD, 1'b0, MEMREAD,                5'b00000, 1'b1);
        push("ld_T8", 1'b0, IR_LD, 1'b0, MEMREAD | READ | MDRIN, 5'b00000, 1'b1);
        push("ld_T9", 1'b0, IR_LD, 1'b0, MDROUT | GRA | RIN,     5'b00000, 1'b1);

        push_fetch(IR_ST);
        push_ld_front(IR_ST, "st_T4_T6");
        push("st_T7", 1'b0, IR_ST, 1'b0, GRA | ROUT | MDRIN, 5'b00010, 1'b1);
        push("st_T8", 1'b0, IR_ST, 1'b0, MEMWRITE,           5'b00010, 1'b1);

        for (int cf = 0; cf < 2; cf++) begin
            push_fetch(IR_BR);
            push("br_T4", 1'b0, IR_BR, cf[0], GRA | ROUT | CONIN, 5'b10011, 1'b1);
            push("br_T5", 1'b0, IR_BR, cf[0], PCOUT | YIN,        5'b10011, 1'b1);
            push("br_T6", 1'b0, IR_BR, cf[0], COUT | ZIN,         ADD,      1'b1);
            push("br_T7", 1'b0, IR_BR, cf[0], cf[0] ? (ZLOWOUT | PCIN) : ZLOWOUT, 5'b10011, 1'b1);
        end

        push_fetch(IR_MUL);
        push("mul_T4", 1'b0, IR_MUL, 1'b0, GRA | ROUT | YIN,  5'b10000, 1'b1);
        push("mul_T5", 1'b0, IR_MUL, 1'b0, GRB | ROUT | ZIN,  5'b10000, 1'b1);
        push("mul_T6", 1'b0, IR_MUL, 1'b0, ZLOWOUT | LOIN,    5'b10000, 1'b1);
        push("mul_T7", 1'b0, IR_MUL, 1'b0, ZHIGHOUT | HIIN,   5'b10000, 1'b1);

        push_fetch(IR_NEG);
        push("neg_T4", 1'b0, IR_NEG, 1'b0, GRB | ROUT | ZIN,    5'b10001, 1'b1);
        push("neg_T5", 1'b0, IR_NEG, 1'b0, ZLOWOUT | GRA | RIN, 5'b10001, 1'b1);

        push_fetch(IR_MFHI);
        push("mfhi_T4", 1'b0, IR_MFHI, 1'b0, HIOUT | GRA | RIN, 5'b11000, 1'b1);

        push_fetch(IR_ADDI);
        push("addi_T4", 1'b0, IR_ADDI, 1'b0, GRB | ROUT | YIN,    5'b01100, 1'b1);
        push("addi_T5", 1'b0, IR_ADDI, 1'b0, COUT | ZIN,          5'b01100, 1'b1);
        push("addi_T6", 1'b0, IR_ADDI, 1'b0, ZLOWOUT | GRA | RIN, 5'b01100, 1'b1);

        push_fetch(IR_NOP);
        push("nop_T4", 1'b0, IR_NOP, 1'b0, NONE, 5'b11010, 1'b1);

        push_fetch(IR_HALT);
        push("halt_T4", 1'b0, IR_HALT, 1'b0, NONE, 5'b11011, 1'b1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Parked in HALT: nothing moves regardless of ir or con_ff.
        for (int i = 0; i < 20; i++) begin
            v.name = "halted"; v.clear = 1'b0; v.ir = (i % 2 == 0) ? IR_ADD : IR_HALT;
            v.con_ff = i[0]; v.ctrl = NONE; v.alu = 5'd0; v.run = 1'b0;
            apply(v);
        end

        // Clear leaves HALT, then aborts a load while its memory read is in flight.
        vecs.delete();
        push("clr_halt", 1'b1, IR_LD, 1'b0, NONE, 5'd0, 1'b1);
        push_fetch(IR_LD);
        push_ld_front(IR_LD, "abort_T4_T6");
        push("clr_ld_T7", 1'b1, IR_LD, 1'b0, NONE, 5'd0, 1'b1);
        push("after_T0", 1'b0, IR_LD, 1'b0, PCOUT | MARIN | INCPC | ZIN, 5'b00000, 1'b1);
        push("after_T1", 1'b0, IR_LD, 1'b0, ZLOWOUT | PCIN | MEMREAD,    5'b00000, 1'b1);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
